grad_batch_seq: RTL and testbench

GRAD_BATCH_SEQ -- requirements
Module: grad_batch_seq

---
 rtl/grad_batch_seq_if.sv | 23 ++
 rtl/grad_batch_seq.sv | 117 +++++++++++
 tb/tb_grad_batch_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/grad_batch_seq_if.sv
// Batch-offer, downstream-busy and DAC-word signals of grad_batch_seq in one bundle.
// master drives offers and busy (host/bench side); slave is the sequencer.
interface grad_batch_seq_if;
    logic        upd;
    logic [63:0] val;
    logic [3:0]  ch_en;
    logic        clr_err;
    logic        busy;
    logic [31:0] data;
    logic        valid;
    logic        idle;
    logic        err;

    modport master (
        output upd, val, ch_en, clr_err, busy,
        input  data, valid, idle, err
    );

    modport slave (
        input  upd, val, ch_en, clr_err, busy,
        output data, valid, idle, err
    );
endinterface

// File: rtl/grad_batch_seq.sv
// Serialises 4-channel DAC batches into single-word writes; first word one cycle after a load, then >=3 cycles apart.
// Waits on downstream busy (with timeout), holds one pending batch; a further offer overwrites it and flags err.
module grad_batch_seq #(
    parameter int         BUSY_TMO  = 4,
    parameter logic [7:0] DAC_ADDR0 = 8'h08
) (
    input logic            clk,
    input logic            rst,
    grad_batch_seq_if.slave bus
);
    localparam int CW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t        state, nxt;
    logic [63:0]   act_val, pnd_val;
    logic [3:0]    act_rem, pnd_msk;
    logic [CW-1:0] tmo_cnt;
    logic [31:0]   data_q;
    logic          err_q;

    logic          accept, pnd_full, issue, decide, move, last;
    logic [1:0]    ch;
    logic [3:0]    rem_nxt;
    logic [31:0]   word;

    assign accept   = bus.upd && (bus.ch_en != 4'd0);
    assign pnd_full = (pnd_msk != 4'd0);

    always_comb begin
        ch = 2'd0;
        casez (act_rem)
            4'b???1: ch = 2'd0;
            4'b??10: ch = 2'd1;
            4'b?100: ch = 2'd2;
            4'b1000: ch = 2'd3;
            default: ch = 2'd0;
        endcase
    end

    // Lowest channel goes first, so the word is "last" once nothing remains above it.
    assign rem_nxt = act_rem & ~(4'b0001 << ch);
    assign last    = (rem_nxt == 4'd0);
    assign word    = {5'd0, ch, last, DAC_ADDR0 + {6'd0, ch}, act_val[{ch, 4'd0} +: 16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        issue  = 1'b0;
        decide = 1'b0;
        case (state)
            IDLE:    if (accept) nxt = ISSUE;
            ISSUE:   if (!bus.busy) begin
                         issue = 1'b1;
                         nxt   = WAIT_HI;
                     end
            WAIT_HI: if (bus.busy)                 nxt    = WAIT_LO;
                     else if (tmo_cnt == TMO_LAST) decide = 1'b1;
            WAIT_LO: if (!bus.busy) decide = 1'b1;
            default: nxt = IDLE;
        endcase
        if (decide) nxt = ((act_rem != 4'd0) || pnd_full) ? ISSUE : IDLE;
    end

    assign move = decide && (act_rem == 4'd0) && pnd_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_val <= '0;
            act_rem <= '0;
            pnd_val <= '0;
            pnd_msk <= '0;
            tmo_cnt <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == WAIT_HI) tmo_cnt <= tmo_cnt + CW'(1);
            else                  tmo_cnt <= '0;

            if (issue) begin
                act_rem <= rem_nxt;
                data_q  <= word;
            end

            if (move) begin
                act_val <= pnd_val;
                act_rem <= pnd_msk;
            end

            // A move frees the pending slot before a same-cycle offer lands in it.
            if (accept) begin
                if (state == IDLE) begin
                    act_val <= bus.val;
                    act_rem <= bus.ch_en;
                end else begin
                    pnd_val <= bus.val;
                    pnd_msk <= bus.ch_en;
                end
            end else if (move) begin
                pnd_msk <= 4'd0;
            end

            if (accept && (state != IDLE) && pnd_full && !move) err_q <= 1'b1;
            else if (bus.clr_err)                              err_q <= 1'b0;
        end
    end

    assign bus.valid = issue;
    assign bus.data  = issue ? word : data_q;
    assign bus.idle  = (state == IDLE) && !pnd_full;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_grad_batch_seq.sv
// Directed bench for grad_batch_seq: queue-based word model checked on every cycle, plus literal words.
module tb_grad_batch_seq;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grad_batch_seq_if bus();

    grad_batch_seq #(.BUSY_TMO(TMO), .DAC_ADDR0(8'h08)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    int          stamps[$];
    int          vcount = 0;
    int          cyc = 0;
    int          busy_mode = 0;
    int          durs[4] = '{2, 7, 40, 13};
    int          didx = 0;
    logic [31:0] held = 32'd0;
    logic [31:0] e;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(int c, logic lst, logic [15:0] v);
        logic [1:0] cc;
        logic [7:0] a;
        cc = 2'(c);
        a  = 8'(8'h08 + c);
        return {5'd0, cc, lst, a, v};
    endfunction

    task automatic push_batch(logic [63:0] v, logic [3:0] m);
        for (int c = 0; c < 4; c++)
            if (m[c]) exp_q.push_back(mk_word(c, (m >> (c + 1)) == 4'd0, v[16*c +: 16]));
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic upd_on(logic [63:0] v, logic [3:0] m);
        bus.upd   = 1'b1;
        bus.val   = v;
        bus.ch_en = m;
    endtask

    task automatic upd_off();
        bus.upd     = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic send(logic [63:0] v, logic [3:0] m);
        upd_on(v, m);
        tick(1);
        upd_off();
    endtask

    task automatic wait_idle(string name, int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 32'(bus.idle), 32'd1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        tick(1);
    endtask

    // Per-cycle compare: every valid word must be the next expected one; otherwise data holds.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            held = 32'd0;
        end else if (bus.valid) begin
            vcount++;
            stamps.push_back(cyc);
            chk("valid_while_busy", 32'(bus.busy), 32'd0);
            chk("pad_zero", 32'(bus.data[31:27]), 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got 0x%08h, required no valid", bus.data);
            end else begin
                e = exp_q.pop_front();
                chk("word", bus.data, e);
            end
            held = bus.data;
        end else begin
            chk("data_hold", bus.data, held);
        end
    end

    // Downstream model: raises busy the cycle after each word and holds it for a table-driven time.
    initial begin
        bus.busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_mode != 0 && bus.valid && !rst) begin
                @(posedge clk);
                #1 bus.busy = 1'b1;
                repeat (durs[didx]) @(posedge clk);
                #1 bus.busy = 1'b0;
                didx = (didx + 1) % 4;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vbase;
        int n;
        bus.upd = 1'b0; bus.val = '0; bus.ch_en = '0; bus.clr_err = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_data", bus.data, 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick(1);

        // Full batch, literal words
        busy_mode = 1;
        exp_q.push_back(32'h00080001);
        exp_q.push_back(32'h02090002);
        exp_q.push_back(32'h040A0003);
        exp_q.push_back(32'h070B0004);
        vbase = vcount;
        send(64'h0004_0003_0002_0001, 4'hF);
        wait_idle("full", 400);
        chk("full_count", 32'(vcount - vbase), 32'd4);

        // Sparse mask, literal words
        exp_q.push_back(32'h0008AAAA);
        exp_q.push_back(32'h050ABBBB);
        vbase = vcount;
        send(64'h2222_BBBB_1111_AAAA, 4'b0101);
        wait_idle("sparse", 300);
        chk("sparse_count", 32'(vcount - vbase), 32'd2);

        // Overrun: second batch dropped, third kept; set beats a coincident clear
        push_batch(64'h0013_0012_0011_0010, 4'hF);
        push_batch(64'h0033_0032_0031_0030, 4'b0110);
        vbase = vcount;
        send(64'h0013_0012_0011_0010, 4'hF);
        tick(1);
        send(64'h0023_0022_0021_0020, 4'b0011);
        tick(1);
        upd_on(64'h0033_0032_0031_0030, 4'b0110);
        bus.clr_err = 1'b1;
        tick(1);
        upd_off();
        @(negedge clk);
        chk("err_set_wins", 32'(bus.err), 32'd1);
        tick(1);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(bus.err), 32'd0);
        tick(1);
        wait_idle("overrun", 600);
        chk("overrun_count", 32'(vcount - vbase), 32'd6);

        // Offer lands in the same cycle as the pending-to-active move (busy tied low)
        busy_mode = 0;
        push_batch(64'h0000_0000_0000_0D0D, 4'b0001);
        push_batch(64'h0E0E_0000_0000_0000, 4'b1000);
        push_batch(64'h0000_0F02_0F01_0000, 4'b0110);
        vbase = vcount;
        upd_on(64'h0000_0000_0000_0D0D, 4'b0001);
        tick(1); upd_off();
        tick(1); upd_on(64'h0E0E_0000_0000_0000, 4'b1000);
        tick(1); upd_off();
        tick(2); upd_on(64'h0000_0F02_0F01_0000, 4'b0110);
        tick(1); upd_off();
        @(negedge clk);
        chk("move_no_err", 32'(bus.err), 32'd0);
        tick(1);
        wait_idle("move", 300);
        chk("move_count", 32'(vcount - vbase), 32'd4);

        // Lost handshake: each word followed by the timeout, then the next issue
        stamps.delete();
        push_batch(64'h5004_5003_5002_5001, 4'hF);
        send(64'h5004_5003_5002_5001, 4'hF);
        wait_idle("tmo", 200);
        chk("tmo_words", 32'(stamps.size()), 32'd4);
        for (int i = 1; i < stamps.size(); i++)
            chk("tmo_spacing", 32'(stamps[i] - stamps[i-1]), 32'(TMO + 1));

        // Reset between 2nd and 3rd word, then restart
        busy_mode = 1;
        exp_q.push_back(mk_word(0, 1'b0, 16'h6001));
        exp_q.push_back(mk_word(1, 1'b0, 16'h6002));
        vbase = vcount;
        send(64'h6004_6003_6002_6001, 4'hF);
        n = 0;
        @(negedge clk); #1;
        while ((vcount - vbase) < 2 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_mid_two_words", 32'(vcount - vbase), 32'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(bus.valid), 32'd0);
        chk("rst_mid_data", bus.data, 32'd0);
        chk("rst_mid_idle", 32'(bus.idle), 32'd1);
        chk("rst_mid_err", 32'(bus.err), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(50);
        chk("rst_mid_no_more", 32'(vcount - vbase), 32'd2);
        chk("rst_mid_drained", 32'(exp_q.size()), 32'd0);
        push_batch(64'h7004_7003_7002_7001, 4'hF);
        vbase = vcount;
        send(64'h7004_7003_7002_7001, 4'hF);
        wait_idle("restart", 400);
        chk("restart_count", 32'(vcount - vbase), 32'd4);

        // Empty mask while idle is ignored
        vbase = vcount;
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'h0);
        repeat (6) @(negedge clk);
        chk("mask0_count", 32'(vcount - vbase), 32'd0);
        chk("mask0_idle", 32'(bus.idle), 32'd1);
        chk("mask0_err", 32'(bus.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
